// File: rtl/fifo_flops_status.sv
`default_nettype none
// ============================================================================
// Module   : fifo_flops_status
// Brief    : Flop-based synchronous FIFO with occupancy count, almost-full /
//            almost-empty thresholds and sticky overflow/underflow flags.
//            Define FIFO_FLOPS_FWFT_EN for first-word-fall-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_flops_status #(
  parameter int depth    = 16,
  parameter int bits     = 16,
  parameter int AF_LEVEL = depth - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [bits-1:0]            Din,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [bits-1:0]            Dout,
  output logic                       full,
  output logic                       pndng,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int c_CW = $clog2(depth + 1);

  logic [bits-1:0] r_mem [depth];
  logic [c_PW-1:0] r_wp;
  logic [c_PW-1:0] r_rp;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;
  logic            r_underflow;

  logic            w_full;
  logic            w_pndng;
  logic            w_wr;
  logic            w_rd;

  assign w_full  = (r_count == c_CW'(depth));
  assign w_pndng = (r_count != '0);
  // At full a concurrent pop frees the slot the push fills.
  assign w_wr    = push && (!w_full || pop);
  assign w_rd    = pop && w_pndng;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= Din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= (r_wp == c_PW'(depth - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= (r_rp == c_PW'(depth - 1)) ? '0 : r_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && w_full && !pop) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (pop && !w_pndng) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FLOPS_FWFT_EN
  assign Dout = w_pndng ? r_mem[r_rp] : '0;
`else
  logic [bits-1:0] r_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rd) begin
      r_dout <= r_mem[r_rp];
    end
  end

  assign Dout = r_dout;
`endif

  assign full         = w_full;
  assign pndng        = w_pndng;
  assign count        = r_count;
  assign almost_full  = (r_count >= c_CW'(AF_LEVEL));
  assign almost_empty = (r_count <= c_CW'(AE_LEVEL));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_flops_status.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_flops_status
// Brief    : Directed self-checking bench for fifo_flops_status (both read
//            modes, selected by FIFO_FLOPS_FWFT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_flops_status;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Din = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] Dout;
  logic        full;
  logic        pndng;
  logic [4:0]  count;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int failures = 0;

  fifo_flops_status #(
    .depth(16), .bits(16), .AF_LEVEL(14), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop),
    .clr_err(clr_err), .Dout(Dout), .full(full), .pndng(pndng),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (count !== 5'd0 || pndng !== 1'b0 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || Dout !== 16'h0) begin
      failures++;
      $display("FAIL reset: count=%0d pndng=%b full=%b ae=%b af=%b ov=%b uf=%b Dout=%h, required 0 0 0 1 0 0 0 0000",
               count, pndng, full, almost_empty, almost_full, overflow, underflow, Dout);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; Din = 16'(i);
      tick();
      checks++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16)) begin
        failures++;
        $display("FAIL fill[%0d]: count=%0d af=%b full=%b, required %0d %b %b",
                 i, count, almost_full, full, i + 1, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
`ifdef FIFO_FLOPS_FWFT_EN
      checks++;
      if (Dout !== 16'(i)) begin
        failures++; $display("FAIL drain_data[%0d]: Dout=%h, required %h", i, Dout, 16'(i));
      end
      tick();
`else
      tick();
      checks++;
      if (Dout !== 16'(i)) begin
        failures++; $display("FAIL drain_data[%0d]: Dout=%h, required %h", i, Dout, 16'(i));
      end
`endif
      checks++;
      if (pndng !== (i < 15)) begin
        failures++; $display("FAIL drain_pndng[%0d]: pndng=%b, required %b", i, pndng, (i < 15));
      end
    end
    pop = 1'b0;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 40; i++) begin
      push = 1'b1; Din = 16'(i);
      tick();
      checks++;
      if (count !== ((i < 16) ? 5'(i + 1) : 5'd16) || overflow !== (i >= 16)) begin
        failures++;
        $display("FAIL ovf_push[%0d]: count=%0d ov=%b, required %0d %b",
                 i, count, overflow, (i < 16) ? i + 1 : 16, (i >= 16));
      end
    end
    push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
`ifdef FIFO_FLOPS_FWFT_EN
      checks++;
      if (Dout !== 16'(i)) begin
        failures++; $display("FAIL ovf_pop[%0d]: Dout=%h, required %h", i, Dout, 16'(i));
      end
      tick();
`else
      tick();
      checks++;
      if (Dout !== 16'(i)) begin
        failures++; $display("FAIL ovf_pop[%0d]: Dout=%h, required %h", i, Dout, 16'(i));
      end
`endif
    end
    pop = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 5'd0) begin
      failures++; $display("FAIL ovf_clear: ov=%b count=%0d, required 0 0", overflow, count);
    end
  endtask

  task automatic test_underflow;
    logic [15:0] held;
`ifdef FIFO_FLOPS_FWFT_EN
    held = 16'h0000;
`else
    held = 16'h000F;
`endif
    for (int i = 0; i < 20; i++) begin
      pop = 1'b1;
      tick();
      checks++;
      if (underflow !== 1'b1 || count !== 5'd0 || Dout !== held) begin
        failures++;
        $display("FAIL udf_pop[%0d]: uf=%b count=%0d Dout=%h, required 1 0 %h",
                 i, underflow, count, Dout, held);
      end
    end
    push = 1'b1; clr_err = 1'b1; Din = 16'h7777;
    tick();
    push = 1'b0; clr_err = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1) begin
      failures++; $display("FAIL udf_set_wins: count=%0d uf=%b, required 1 1", count, underflow);
    end
    pop = 1'b1;
`ifdef FIFO_FLOPS_FWFT_EN
    checks++;
    if (Dout !== 16'h7777) begin
      failures++; $display("FAIL udf_data: Dout=%h, required 7777", Dout);
    end
    tick();
`else
    tick();
    checks++;
    if (Dout !== 16'h7777) begin
      failures++; $display("FAIL udf_data: Dout=%h, required 7777", Dout);
    end
`endif
    pop = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (underflow !== 1'b0 || count !== 5'd0) begin
      failures++; $display("FAIL udf_clear: uf=%b count=%0d, required 0 0", underflow, count);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; Din = 16'h0010 + 16'(i);
      tick();
    end
    for (int k = 0; k < 15; k++) begin
      // k<10: push+pop with A5A5, k>=10: drain only
      push = (k < 10); pop = 1'b1; Din = 16'hA5A5;
      exp = (k < 5) ? 16'h0010 + 16'(k) : 16'hA5A5;
`ifdef FIFO_FLOPS_FWFT_EN
      checks++;
      if (Dout !== exp) begin
        failures++; $display("FAIL b2b_data[%0d]: Dout=%h, required %h", k, Dout, exp);
      end
      tick();
`else
      tick();
      checks++;
      if (Dout !== exp) begin
        failures++; $display("FAIL b2b_data[%0d]: Dout=%h, required %h", k, Dout, exp);
      end
`endif
      checks++;
      if (count !== ((k < 10) ? 5'd5 : 5'(14 - k))) begin
        failures++;
        $display("FAIL b2b_count[%0d]: count=%0d, required %0d", k, count, (k < 10) ? 5 : 14 - k);
      end
    end
    pop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; Din = 16'h0100 + 16'(i);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      push = (k < 4); pop = 1'b1; Din = 16'h0200 + 16'(k);
      exp = (k < 16) ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k - 16);
`ifdef FIFO_FLOPS_FWFT_EN
      checks++;
      if (Dout !== exp) begin
        failures++; $display("FAIL full_b2b_data[%0d]: Dout=%h, required %h", k, Dout, exp);
      end
      tick();
`else
      tick();
      checks++;
      if (Dout !== exp) begin
        failures++; $display("FAIL full_b2b_data[%0d]: Dout=%h, required %h", k, Dout, exp);
      end
`endif
      checks++;
      if (count !== ((k < 4) ? 5'd16 : 5'(19 - k)) || overflow !== 1'b0) begin
        failures++;
        $display("FAIL full_b2b_status[%0d]: count=%0d ov=%b, required %0d 0",
                 k, count, overflow, (k < 4) ? 16 : 19 - k);
      end
    end
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; Din = 16'h0300 + 16'(i);
      tick();
    end
    checks++;
    if (count !== 5'd9) begin
      failures++; $display("FAIL arst_pre: count=%0d, required 9", count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0 || pndng !== 1'b0 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || Dout !== 16'h0) begin
      failures++;
      $display("FAIL arst_async: count=%0d pndng=%b full=%b ae=%b af=%b ov=%b uf=%b Dout=%h, required 0 0 0 1 0 0 0 0000",
               count, pndng, full, almost_empty, almost_full, overflow, underflow, Dout);
    end
    push = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    push = 1'b1; Din = 16'h1234;
    tick();
    push = 1'b0; pop = 1'b1;
`ifdef FIFO_FLOPS_FWFT_EN
    checks++;
    if (Dout !== 16'h1234) begin
      failures++; $display("FAIL arst_post: Dout=%h, required 1234", Dout);
    end
    tick();
`else
    tick();
    checks++;
    if (Dout !== 16'h1234) begin
      failures++; $display("FAIL arst_post: Dout=%h, required 1234", Dout);
    end
`endif
    pop = 1'b0;
    checks++;
    if (count !== 5'd0) begin
      failures++; $display("FAIL arst_post_count: count=%0d, required 0", count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
